// File: rtl/fir3_pkg.sv
// Shared constants for the 3-parallel FIR lane scheduler.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package fir3_pkg;
    localparam int NBIT_DEFAULT = 12;
    localparam int LANE_3K      = 0;
    localparam int LANE_3K1     = 1;
    localparam int LANE_3K2     = 2;
    localparam int TAG_W        = 2;

    // Number of valid lanes in an issued group: 1, 2 or 3.
    typedef logic [TAG_W-1:0] tag_t;
endpackage

// File: rtl/fir3_lane_sched_if.sv
// Bundle of serial-in, filter-side and serial-out signals of the lane scheduler.
// Latency: n/a (wiring only).
// Backpressure: S_RDY gates the serial input; M_RDY stalls the serial output.
interface fir3_lane_sched_if #(parameter int NBIT = fir3_pkg::NBIT_DEFAULT) ();
    logic [NBIT-1:0] S_DIN;
    logic            S_VIN;
    logic            S_RDY;
    logic            FLUSH;
    logic [NBIT-1:0] P_DIN3K;
    logic [NBIT-1:0] P_DIN3K1;
    logic [NBIT-1:0] P_DIN3K2;
    logic            P_VIN;
    logic [NBIT-1:0] P_DOUT3K;
    logic [NBIT-1:0] P_DOUT3K1;
    logic [NBIT-1:0] P_DOUT3K2;
    logic            P_VOUT;
    logic [NBIT-1:0] M_DOUT;
    logic            M_VOUT;
    logic            M_RDY;
    logic            OVF;

    // Environment side: serial source, filter model, serial sink.
    modport master (
        output S_DIN, S_VIN, FLUSH, P_DOUT3K, P_DOUT3K1, P_DOUT3K2, P_VOUT, M_RDY,
        input  S_RDY, P_DIN3K, P_DIN3K1, P_DIN3K2, P_VIN, M_DOUT, M_VOUT, OVF
    );

    // Scheduler side.
    modport slave (
        input  S_DIN, S_VIN, FLUSH, P_DOUT3K, P_DOUT3K1, P_DOUT3K2, P_VOUT, M_RDY,
        output S_RDY, P_DIN3K, P_DIN3K1, P_DIN3K2, P_VIN, M_DOUT, M_VOUT, OVF
    );
endinterface

// File: rtl/fir3_sync_fifo.sv
// Generic synchronous FIFO, DEPTH a power of two; head is the oldest entry.
// Latency: push at edge n is visible at head (empty=0) in cycle n+1.
// Backpressure: push ignored when full, pop ignored when empty.
module fir3_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int          AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FULL = DEPTH;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL[AW:0]);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    // Storage needs no reset: occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

// File: rtl/fir3_lane_sched.sv
// Packs serial samples into 3-lane groups for the unfolded FIR and re-serialises its results.
// Latency: third sample accepted at edge n -> P_VIN in cycle n+1; result captured at edge r -> M_VOUT in cycle r+1.
// Backpressure: credits (one per output-FIFO group) gate S_RDY, so the non-stalling filter never overruns the FIFO.
// Ports: CLK/RST (sync, active-high); bus.slave carries S_* serial in, FLUSH, P_* filter lanes, M_* serial out, OVF.
module fir3_lane_sched #(
    parameter int NBIT  = fir3_pkg::NBIT_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic           CLK,
    input  logic           RST,
    fir3_lane_sched_if.slave bus
);
    import fir3_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    logic [1:0]        fill;
    logic [1:0]        fill_inc;
    logic              accept;
    logic              issue;
    logic              transfer;
    logic              last_lane;
    logic              wr_data;
    logic              ovf_evt;
    logic              s_rdy;
    logic              p_vin;
    logic              ovf;
    logic [NBIT-1:0]   stg  [3];
    logic [NBIT-1:0]   grp  [3];
    logic [NBIT-1:0]   lane [3];
    logic [NBIT-1:0]   ret  [3];
    logic [NBIT-1:0]   dat_lane [3];
    logic [3*NBIT-1:0] push_dat;
    logic [3*NBIT-1:0] head_dat;
    logic [NBIT-1:0]   m_dout;
    logic [CW-1:0]     credits;
    logic [CW-1:0]     credits_nxt;
    logic [CW-1:0]     outstanding;  // groups issued but not yet returned
    logic [1:0]        idx;
    tag_t              head_tag;
    logic              tag_full;
    logic              tag_empty;
    logic              dat_full;
    logic              dat_empty;

    // fill_inc counts the current sample too, so it is both the
    // completion test and the tag of whatever group issues now.
    assign accept    = bus.S_VIN & s_rdy;
    assign fill_inc  = fill + {1'b0, accept};
    assign issue     = (fill_inc == 2'd3) || (bus.FLUSH && (fill_inc != 2'd0));
    assign transfer  = ~dat_empty & bus.M_RDY;
    assign last_lane = transfer && (idx == head_tag - 2'd1);
    assign wr_data   = bus.P_VOUT && (outstanding != '0);
    assign ovf_evt   = bus.P_VOUT && (outstanding == '0);
    assign credits_nxt = credits - CW'(issue) + CW'(last_lane);

    assign ret[LANE_3K]  = bus.P_DOUT3K;
    assign ret[LANE_3K1] = bus.P_DOUT3K1;
    assign ret[LANE_3K2] = bus.P_DOUT3K2;

    always_comb begin
        push_dat = '0;
        m_dout   = '0;
        for (int i = 0; i < 3; i++) begin
            // The sample accepted this cycle joins the group being issued.
            grp[i] = (accept && (fill == 2'(i))) ? bus.S_DIN : stg[i];
            push_dat[i*NBIT +: NBIT] = ret[i];
            dat_lane[i] = head_dat[i*NBIT +: NBIT];
            if (!dat_empty && (idx == 2'(i))) m_dout = dat_lane[i];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fill        <= '0;
            s_rdy       <= 1'b0;
            p_vin       <= 1'b0;
            ovf         <= 1'b0;
            credits     <= CW'(DEPTH);
            outstanding <= '0;
            idx         <= '0;
            for (int i = 0; i < 3; i++) begin
                stg[i]  <= '0;
                lane[i] <= '0;
            end
        end else begin
            p_vin       <= issue;
            s_rdy       <= (credits_nxt != '0);
            credits     <= credits_nxt;
            fill        <= issue ? 2'd0 : fill_inc;
            outstanding <= outstanding + CW'(issue) - CW'(wr_data);
            if (ovf_evt) ovf <= 1'b1;
            if (transfer) idx <= last_lane ? 2'd0 : idx + 2'd1;
            for (int i = 0; i < 3; i++) begin
                if (accept && (fill == 2'(i))) stg[i] <= bus.S_DIN;
                // Lanes beyond the group's tag are zero, never stale data.
                if (issue) lane[i] <= (2'(i) < fill_inc) ? grp[i] : '0;
            end
        end
    end

    fir3_sync_fifo #(.WIDTH(TAG_W), .DEPTH(DEPTH)) u_tag_fifo (
        .clk      (CLK),
        .rst      (RST),
        .push     (issue),
        .push_dat (fill_inc),
        .pop      (last_lane),
        .head     (head_tag),
        .full     (tag_full),
        .empty    (tag_empty)
    );

    fir3_sync_fifo #(.WIDTH(3*NBIT), .DEPTH(DEPTH)) u_dat_fifo (
        .clk      (CLK),
        .rst      (RST),
        .push     (wr_data),
        .push_dat (push_dat),
        .pop      (last_lane),
        .head     (head_dat),
        .full     (dat_full),
        .empty    (dat_empty)
    );

    assign bus.S_RDY    = s_rdy;
    assign bus.P_VIN    = p_vin;
    assign bus.P_DIN3K  = lane[LANE_3K];
    assign bus.P_DIN3K1 = lane[LANE_3K1];
    assign bus.P_DIN3K2 = lane[LANE_3K2];
    assign bus.M_VOUT   = ~dat_empty;
    assign bus.M_DOUT   = m_dout;
    assign bus.OVF      = ovf;

    // Credits make these unreachable; they guard the bookkeeping.
    a_dat_room: assert property (@(posedge CLK) disable iff (RST) !(wr_data && dat_full));
    a_tag_room: assert property (@(posedge CLK) disable iff (RST) !(issue && tag_full));
    a_tag_head: assert property (@(posedge CLK) disable iff (RST) !(!dat_empty && tag_empty));
    a_credits:  assert property (@(posedge CLK) disable iff (RST) credits <= CW'(DEPTH));
endmodule

// File: tb/tb_fir3_lane_sched.sv
module tb_fir3_lane_sched;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fir3_lane_sched_if #(.NBIT(12)) bus ();

    fir3_lane_sched #(.NBIT(12), .DEPTH(4)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int compared   = 0;
    int mismatched = 0;
    logic [11:0] exp_q[$];
    logic spur = 1'b0;

    typedef struct {
        int          due;
        logic [11:0] l0;
        logic [11:0] l1;
        logic [11:0] l2;
    } ret_t;
    ret_t rq[$];
    int ncyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [11:0] x);
        chk("send_rdy", {31'd0, bus.S_RDY}, 1);
        bus.S_VIN = 1'b1;
        bus.S_DIN = x;
        exp_q.push_back(12'(x * 10));
        tick();
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_drain"}, exp_q.size(), 0);
    endtask

    task automatic chk_lanes(input string tag, input logic [11:0] a, input logic [11:0] b, input logic [11:0] c);
        chk({tag, "_pvin"}, {31'd0, bus.P_VIN}, 1);
        chk({tag, "_l0"}, {20'd0, bus.P_DIN3K}, {20'd0, a});
        chk({tag, "_l1"}, {20'd0, bus.P_DIN3K1}, {20'd0, b});
        chk({tag, "_l2"}, {20'd0, bus.P_DIN3K2}, {20'd0, c});
    endtask

    // Filter model: a zero (padded) lane comes back as 99, any other x as 10*x.
    function automatic logic [11:0] fx(input logic [11:0] x);
        return (x == 12'd0) ? 12'd99 : 12'(x * 10);
    endfunction

    // Fixed-latency filter: result driven 5 cycles after P_VIN is seen.
    initial begin
        ret_t r;
        bus.P_VOUT = 1'b0;
        bus.P_DOUT3K = '0;
        bus.P_DOUT3K1 = '0;
        bus.P_DOUT3K2 = '0;
        forever begin
            @(negedge clk);
            ncyc++;
            bus.P_VOUT = 1'b0;
            if (bus.P_VIN === 1'b1) begin
                r.due = ncyc + 5;
                r.l0 = fx(bus.P_DIN3K);
                r.l1 = fx(bus.P_DIN3K1);
                r.l2 = fx(bus.P_DIN3K2);
                rq.push_back(r);
            end
            if (spur) begin
                spur = 1'b0;
                bus.P_VOUT = 1'b1;
                bus.P_DOUT3K = 12'd5;
                bus.P_DOUT3K1 = 12'd5;
                bus.P_DOUT3K2 = 12'd5;
            end else if (rq.size() > 0 && rq[0].due == ncyc) begin
                r = rq.pop_front();
                bus.P_VOUT = 1'b1;
                bus.P_DOUT3K = r.l0;
                bus.P_DOUT3K1 = r.l1;
                bus.P_DOUT3K2 = r.l2;
            end
        end
    end

    // Scoreboard: every serial transfer must match the oldest expected sample.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.M_VOUT === 1'b1 && bus.M_RDY === 1'b1) begin
            chk("out_expected", {31'd0, exp_q.size() > 0}, 1);
            if (exp_q.size() > 0) chk("out_data", {20'd0, bus.M_DOUT}, {20'd0, exp_q.pop_front()});
        end
    end

    initial begin
        int acc;
        int issues;
        logic [11:0] v;

        rst = 1'b1;
        bus.S_VIN = 1'b0;
        bus.S_DIN = '0;
        bus.FLUSH = 1'b0;
        bus.M_RDY = 1'b1;
        repeat (3) tick();
        chk("rst_srdy", {31'd0, bus.S_RDY}, 0);
        chk("rst_pvin", {31'd0, bus.P_VIN}, 0);
        chk("rst_lanes", {bus.P_DIN3K, bus.P_DIN3K1, bus.P_DIN3K2}, 0);
        chk("rst_mvout", {31'd0, bus.M_VOUT}, 0);
        chk("rst_mdout", {20'd0, bus.M_DOUT}, 0);
        chk("rst_ovf", {31'd0, bus.OVF}, 0);
        rst = 1'b0;
        tick();
        chk("rel_srdy", {31'd0, bus.S_RDY}, 1);

        // Full group 1,2,3.
        send(12'd1); send(12'd2); send(12'd3);
        bus.S_VIN = 1'b0;
        chk_lanes("g123", 12'd1, 12'd2, 12'd3);
        tick();
        chk("g123_pulse", {31'd0, bus.P_VIN}, 0);
        wait_drain("g123");

        // Partial group flushed: padded lane must not appear on output.
        send(12'd7); send(12'd8);
        bus.S_VIN = 1'b0;
        bus.FLUSH = 1'b1;
        tick();
        bus.FLUSH = 1'b0;
        chk_lanes("flush2", 12'd7, 12'd8, 12'd0);
        wait_drain("flush2");

        bus.FLUSH = 1'b1;
        tick();
        bus.FLUSH = 1'b0;
        chk("flush_noop", {31'd0, bus.P_VIN}, 0);

        // Third sample with FLUSH -> normal group; then lone sample with FLUSH -> tag 1.
        send(12'd4); send(12'd5);
        bus.S_DIN = 12'd6; bus.FLUSH = 1'b1; exp_q.push_back(12'd60);
        tick();
        chk_lanes("flush3", 12'd4, 12'd5, 12'd6);
        bus.S_DIN = 12'd9; exp_q.push_back(12'd90);
        tick();
        bus.S_VIN = 1'b0; bus.FLUSH = 1'b0;
        chk_lanes("flush1", 12'd9, 12'd0, 12'd0);
        wait_drain("flush");

        // Output stalled: credits limit intake to DEPTH groups.
        bus.M_RDY = 1'b0;
        acc = 0; issues = 0; v = 12'd100;
        for (int i = 0; i < 40; i++) begin
            bus.S_VIN = 1'b1;
            bus.S_DIN = v;
            if (bus.S_RDY) begin
                exp_q.push_back(12'(v * 10));
                v++;
                acc++;
            end
            tick();
            if (bus.P_VIN) issues++;
        end
        bus.S_VIN = 1'b0;
        chk("bp_accepted", acc, 12);
        chk("bp_issued", issues, 4);
        chk("bp_srdy", {31'd0, bus.S_RDY}, 0);
        chk("bp_mvout", {31'd0, bus.M_VOUT}, 1);
        chk("bp_head", {20'd0, bus.M_DOUT}, {20'd0, exp_q[0]});
        tick();
        chk("bp_hold", {20'd0, bus.M_DOUT}, {20'd0, exp_q[0]});
        bus.M_RDY = 1'b1;
        wait_drain("bp");
        tick(); tick();
        chk("bp_srdy_back", {31'd0, bus.S_RDY}, 1);

        // Three groups parked (one credit left); last-lane drain coincides with the issue.
        bus.M_RDY = 1'b0;
        for (int i = 0; i < 9; i++) send(12'(200 + i));
        bus.S_VIN = 1'b0;
        repeat (10) tick();
        chk("co_srdy_pre", {31'd0, bus.S_RDY}, 1);
        bus.M_RDY = 1'b1;
        send(12'd50); send(12'd51); send(12'd52);
        bus.S_VIN = 1'b0;
        chk("co_pvin", {31'd0, bus.P_VIN}, 1);
        chk("co_srdy", {31'd0, bus.S_RDY}, 1);
        wait_drain("co");

        // Return with nothing in flight.
        spur = 1'b1;
        tick(); tick();
        chk("spur_ovf", {31'd0, bus.OVF}, 1);
        chk("spur_mvout", {31'd0, bus.M_VOUT}, 0);
        repeat (3) tick();
        chk("spur_sticky", {31'd0, bus.OVF}, 1);

        // Reset with a group in flight and a partial group pending.
        send(12'd20); send(12'd21); send(12'd22); send(12'd23);
        bus.S_VIN = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        tick();
        chk("mrst_srdy", {31'd0, bus.S_RDY}, 0);
        chk("mrst_pvin", {31'd0, bus.P_VIN}, 0);
        chk("mrst_lanes", {bus.P_DIN3K, bus.P_DIN3K1, bus.P_DIN3K2}, 0);
        chk("mrst_mvout", {31'd0, bus.M_VOUT}, 0);
        chk("mrst_ovf", {31'd0, bus.OVF}, 0);
        rst = 1'b0;
        tick();
        chk("mrst_rel_srdy", {31'd0, bus.S_RDY}, 1);
        chk("mrst_rel_ovf", {31'd0, bus.OVF}, 0);
        repeat (8) tick();
        chk("late_ovf", {31'd0, bus.OVF}, 1);
        chk("late_mvout", {31'd0, bus.M_VOUT}, 0);

        send(12'd1); send(12'd2); send(12'd3);
        bus.S_VIN = 1'b0;
        wait_drain("post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
